// File: rtl/reg_file_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_port_arbiter
// Brief    : Sequences the register file write port and Rs1 read port between
//            the core, a debug access port and a post-reset zero-clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_port_arbiter #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter int STARVE_LIMIT   = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    // core side
    input  logic              i_core_we,
    input  logic [ADDR_W-1:0] i_core_rd,
    input  logic [DATA_W-1:0] i_core_wdata,
    input  logic [ADDR_W-1:0] i_core_rs1,
    output logic              o_stall,
    // debug side
    input  logic              i_dbg_req,
    input  logic              i_dbg_wr,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_wdata,
    output logic              o_dbg_ack,
    output logic [DATA_W-1:0] o_dbg_rdata,
    // register file side
    output logic              o_rf_we,
    output logic [ADDR_W-1:0] o_rf_rd,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic [ADDR_W-1:0] o_rf_rs1,
    input  logic [DATA_W-1:0] i_rf_rdata1
);

    localparam int                c_WAIT_W    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] c_FIRST_REG = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_LAST_REG  = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DBG   = 2'd2
    } state_t;

    localparam state_t c_RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [ADDR_W-1:0]   w_clr_cnt_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_cnt_nxt;
    logic                r_dbg_ack;
    logic [DATA_W-1:0]   r_dbg_rdata;

    logic                w_grant;
    logic                w_we;
    logic                w_stall;
    logic [ADDR_W-1:0]   w_rd;
    logic [ADDR_W-1:0]   w_rs1;
    logic [DATA_W-1:0]   w_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_RST_STATE;
            r_clr_cnt   <= c_FIRST_REG;
            r_wait_cnt  <= '0;
            r_dbg_ack   <= 1'b0;
            r_dbg_rdata <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_cnt  <= w_clr_cnt_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_dbg_ack  <= (r_state == ST_DBG);
            if ((r_state == ST_DBG) && !i_dbg_wr) begin
                r_dbg_rdata <= i_rf_rdata1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_cnt_nxt  = r_clr_cnt;
        w_wait_cnt_nxt = r_wait_cnt;
        w_grant        = 1'b0;
        w_we           = 1'b0;
        w_stall        = 1'b0;
        w_rd           = i_core_rd;
        w_wdata        = i_core_wdata;
        w_rs1          = i_core_rs1;

        case (r_state)
            ST_CLEAR: begin
                // debug requests stay pending; the counter only starts in IDLE
                w_we           = 1'b1;
                w_rd           = r_clr_cnt;
                w_wdata        = '0;
                w_stall        = 1'b1;
                w_wait_cnt_nxt = '0;
                if (r_clr_cnt == c_LAST_REG) begin
                    w_state_nxt   = ST_IDLE;
                    w_clr_cnt_nxt = c_FIRST_REG;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
                end
            end

            ST_IDLE: begin
                w_we    = i_core_we;
                // the ack cycle masks the still-high request of the finished access
                w_grant = i_dbg_req && !r_dbg_ack &&
                          (!i_core_we || (r_wait_cnt == c_WAIT_MAX));
                if (w_grant) begin
                    w_state_nxt    = ST_DBG;
                    w_wait_cnt_nxt = '0;
                end else if (i_dbg_req) begin
                    w_wait_cnt_nxt = (r_wait_cnt == c_WAIT_MAX) ? c_WAIT_MAX
                                                                : r_wait_cnt + c_WAIT_W'(1);
                end else begin
                    w_wait_cnt_nxt = '0;
                end
            end

            ST_DBG: begin
                w_stall        = 1'b1;
                w_wait_cnt_nxt = '0;
                w_state_nxt    = ST_IDLE;
                if (i_dbg_wr) begin
                    w_we    = 1'b1;
                    w_rd    = i_dbg_addr;
                    w_wdata = i_dbg_wdata;
                end else begin
                    w_rs1 = i_dbg_addr;
                end
            end

            default: begin
                w_state_nxt = c_RST_STATE;
            end
        endcase
    end

    // x0 is hardwired; the write strobe is also held low throughout reset
    assign o_rf_we     = w_we && (w_rd != '0) && rst_n;
    assign o_rf_rd     = w_rd;
    assign o_rf_wdata  = w_wdata;
    assign o_rf_rs1    = w_rs1;
    assign o_stall     = w_stall;
    assign o_dbg_ack   = r_dbg_ack;
    assign o_dbg_rdata = r_dbg_rdata;

endmodule
`default_nettype wire

// File: doc/reg_file_port_arbiter.md
# reg_file_port_arbiter

Sequencer and arbiter for the single write port and the Rs1 read port of the register file. It sits between the single-cycle core's decode/writeback stage, a debug/host access port and `reg_file`. After reset it zero-clears x1..x31. It then passes core traffic through unchanged, and inserts one-cycle debug reads/writes by stalling the core, with bounded debug starvation.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (32 registers)
- STARVE_LIMIT, 8, cycles a pending debug request may be deferred by core writes before it is forced through
- CLEAR_ON_RESET, 1, 1 = zero-clear x1..x31 after reset; 0 = go straight to IDLE

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- core_we  in  1  core writeback enable
- core_rd  in  ADDR_W  core destination register
- core_wdata  in  DATA_W  core writeback data
- core_rs1  in  ADDR_W  core Rs1 read address
- stall  out  1  freezes core (PC hold; core's write this cycle is discarded and re-presented)
- dbg_req  in  1  debug access request, level
- dbg_wr  in  1  1 = write, 0 = read; stable while dbg_req high
- dbg_addr  in  ADDR_W  debug register address; stable while dbg_req high
- dbg_wdata  in  DATA_W  debug write data; stable while dbg_req high
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_W  read result, valid when dbg_ack=1
- rf_we  out  1  to reg_file RegWrite
- rf_rd  out  ADDR_W  to reg_file Rd
- rf_wdata  out  DATA_W  to reg_file Write_data
- rf_rs1  out  ADDR_W  to reg_file Rs1
- rf_rdata1  in  DATA_W  from reg_file read_data1

## Operation
- States: CLEAR, IDLE, DBG.
- CLEAR:
  - clr_cnt walks 1..31.
  - rf_we=1, rf_rd=clr_cnt, rf_wdata=0, stall=1, rf_rs1=core_rs1.
  - After writing x31, go to IDLE.
- IDLE:
  - Passthrough: rf_we=core_we, rf_rd=core_rd, rf_wdata=core_wdata, rf_rs1=core_rs1, stall=0.
  - Grant condition: dbg_req=1 AND dbg_ack=0 AND (core_we=0 OR wait_cnt==STARVE_LIMIT).
  - On grant: next state is DBG and wait_cnt clears.
  - If dbg_req=1 but no grant: wait_cnt increments, saturating at STARVE_LIMIT.
  - If dbg_req=0: wait_cnt clears.
- DBG:
  - stall=1. Core inputs are ignored.
  - Write (dbg_wr=1): rf_we=1, rf_rd=dbg_addr, rf_wdata=dbg_wdata.
  - Read (dbg_wr=0): rf_we=0, rf_rs1=dbg_addr. Capture rf_rdata1 into dbg_rdata at the closing edge.
  - Always returns to IDLE after one cycle. dbg_ack=1 in the following cycle.
- x0 protection: rf_we is never asserted with rf_rd=0 (core or debug). A debug write to x0 still acks.
- Debug read of x0 returns whatever reg_file drives (0).
- Requester drops dbg_req in the cycle dbg_ack is seen. dbg_req is ignored in the cycle dbg_ack=1, so back-to-back requests need a fresh assertion.
- dbg_req during CLEAR is held pending, not serviced, until IDLE.

## Timing
- Reset (reset=0, asynchronous) values:
  - state=CLEAR (IDLE if CLEAR_ON_RESET=0), clr_cnt=1, wait_cnt=0, dbg_ack=0, dbg_rdata=0.
  - rf_we forced 0 while reset=0.
  - stall=1 in CLEAR, 0 in IDLE.
- Clear duration: exactly 31 cycles after reset release, rf_we=1 each cycle for x1..x31. First IDLE cycle is cycle 32.
- Debug latency, core idle: dbg_req high in cycle N → DBG in N+1 → dbg_ack in N+2. dbg_rdata is valid in N+2 and held until the next read.
- Starvation bound: with core_we held 1, grant occurs after STARVE_LIMIT deferred cycles. dbg_ack arrives at most STARVE_LIMIT+2 cycles after dbg_req.
- Core stall: exactly one cycle per debug access (DBG state).
- Reset mid-DBG or mid-CLEAR:
  - Any pending access is aborted and no ack is issued.
  - Clear restarts from x1.

## Test plan
- Reset clear: hold reset=0 10 cycles, release → rf_we=1 with rf_rd=1..31 and rf_wdata=0 for 31 cycles, stall=1 throughout, then stall=0.
- Passthrough: IDLE, core_we=1, core_rd=5, core_wdata=0x11111111 → rf_we=1, rf_rd=5, rf_wdata=0x11111111 same cycle, stall=0.
- Debug write then read, core idle:
  - Write: dbg_wr=1, dbg_addr=10, dbg_wdata=0x22222222 → stall=1 one cycle, rf writes x10, dbg_ack two cycles after req.
  - Read: dbg_wr=0, dbg_addr=10 → dbg_rdata=0x22222222 with dbg_ack.
- Starvation: core_we=1 every cycle, dbg read of x5 requested → wait_cnt reaches 8, DBG granted, dbg_ack exactly 10 cycles after dbg_req, core stalled one cycle.
- x0 protection: debug write to x0 with 0xDEADBEEF, and core_we=1 with core_rd=0 → rf_we stays 0 in both cases, dbg_ack still pulses, later read of x0 returns 0.
- Reset mid-operation: assert reset=0 during DBG → dbg_ack never pulses, state returns to CLEAR, clear restarts from x1 after release.
